// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory request handshake and
// holds one instruction word for the decoder until it is consumed.
module instr_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imemReq,
    output logic [15:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [15:0] i_imemData,
    output logic [15:0] o_instrCode,
    output logic        o_instrValid,
    output logic [15:0] o_pc,
    input  logic        i_stall,
    input  logic        i_jump,
    input  logic [9:0]  i_jumpTarget,
    input  logic        i_branchTaken,
    input  logic [15:0] i_branchOffset,
    output logic        o_fetchErr
);

    localparam int unsigned     CntW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);
    localparam logic [15:0]     PcInit  = RESET_PC & 16'hFFFE;

    typedef enum logic [1:0] {StRst, StFetch, StIssue, StHalt} state_e;

    state_e          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [15:0]     code_q, code_d;
    logic [15:0]     ipc_q, ipc_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     pcp2;
    logic [15:0]     next_pc;
    logic            consume;

    assign pcp2    = ipc_q + 16'd2;
    assign consume = valid_q & ~i_stall;

    // Jump replaces the word index inside the current 2 KiB region of pc+2.
    always_comb begin
        if (i_jump) begin
            next_pc = {pcp2[15:11], i_jumpTarget, 1'b0};
        end else if (i_branchTaken) begin
            next_pc = pcp2 + {i_branchOffset[14:0], 1'b0};
        end else begin
            next_pc = pcp2;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        code_d  = code_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            StRst: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (i_imemAck) begin
                    code_d  = i_imemData;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StIssue;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StHalt;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIssue: begin
                if (consume) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StRst;
            pc_q    <= PcInit;
            code_q  <= 16'h0000;
            ipc_q   <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request decodes from state so an async reset drops it immediately.
    assign o_imemReq    = (state_q == StFetch);
    assign o_imemAddr   = pc_q;
    assign o_instrCode  = code_q;
    assign o_instrValid = valid_q;
    assign o_pc         = ipc_q;
    assign o_fetchErr   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetch/issue traffic
// checked against an arithmetic next-PC model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr_code;
    logic        instr_valid;
    logic [15:0] pc;
    logic        stall;
    logic        jump;
    logic [9:0]  jump_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        fetch_err;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_pc;
    logic [15:0] cur_pc;
    logic [15:0] cur_code;

    instr_fetch #(
        .RESET_PC    (16'h0000),
        .ACK_TIMEOUT (16)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_imemReq      (imem_req),
        .o_imemAddr     (imem_addr),
        .i_imemAck      (imem_ack),
        .i_imemData     (imem_data),
        .o_instrCode    (instr_code),
        .o_instrValid   (instr_valid),
        .o_pc           (pc),
        .i_stall        (stall),
        .i_jump         (jump),
        .i_jumpTarget   (jump_target),
        .i_branchTaken  (branch_taken),
        .i_branchOffset (branch_offset),
        .o_fetchErr     (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [15:0] ref_next(input logic [15:0] p, input logic j, input logic b,
                                             input logic [9:0] tgt, input logic [15:0] off);
        int seq;
        int sum;
        seq = (int'(p) + 2) % 65536;
        if (j) return 16'((seq / 2048) * 2048 + int'(tgt) * 2);
        if (b) begin
            sum = seq + 2 * int'($signed(off));
            return 16'(sum);
        end
        return 16'(seq);
    endfunction

    // Branch offset (in words) that lands on dest from the current instruction.
    function automatic logic [15:0] off_to(input logic [15:0] dest);
        logic [15:0] diff;
        diff = dest - (cur_pc + 16'd2);
        return {diff[15], diff[15:1]};
    endfunction

    // Called in FETCH: waits delay cycles, then acks with data.
    task automatic fetch_one(input int delay, input logic [15:0] data);
        chk("fetch_req", {15'd0, imem_req}, 16'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("wait_req", {15'd0, imem_req}, 16'd1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_valid", {15'd0, instr_valid}, 16'd0);
        end
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        chk("got_valid", {15'd0, instr_valid}, 16'd1);
        chk("got_code", instr_code, data);
        chk("got_pc", pc, exp_pc);
        chk("issue_req", {15'd0, imem_req}, 16'd0);
        cur_pc   = exp_pc;
        cur_code = data;
    endtask

    // Called in ISSUE: stalls for n cycles with junk control, then consumes.
    task automatic issue_one(input int n, input logic j, input logic b,
                             input logic [9:0] tgt, input logic [15:0] off);
        for (int i = 0; i < n; i++) begin
            stall         = 1'b1;
            jump          = 1'($urandom);
            branch_taken  = 1'($urandom);
            jump_target   = 10'($urandom);
            branch_offset = 16'($urandom);
            step();
            chk("stall_valid", {15'd0, instr_valid}, 16'd1);
            chk("stall_code", instr_code, cur_code);
            chk("stall_pc", pc, cur_pc);
            chk("stall_req", {15'd0, imem_req}, 16'd0);
        end
        stall         = 1'b0;
        jump          = j;
        branch_taken  = b;
        jump_target   = tgt;
        branch_offset = off;
        step();
        jump         = 1'b0;
        branch_taken = 1'b0;
        exp_pc       = ref_next(cur_pc, j, b, tgt, off);
        chk("consume_valid", {15'd0, instr_valid}, 16'd0);
        chk("next_req", {15'd0, imem_req}, 16'd1);
        chk("next_addr", imem_addr, exp_pc);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_data = 16'h0; stall = 1'b0; jump = 1'b0;
        jump_target = 10'h0; branch_taken = 1'b0; branch_offset = 16'h0;
        exp_pc = 16'h0; cur_pc = 16'h0; cur_code = 16'h0;
        step();
        step();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_code", instr_code, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_err", {15'd0, fetch_err}, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        rst = 1'b0;
        step();

        // Back-to-back same-cycle acks.
        fetch_one(0, 16'h0401);
        issue_one(0, 1'b0, 1'b0, 10'h0, 16'h0);
        chk("seq_addr", imem_addr, 16'h0002);
        fetch_one(0, 16'h0802);

        // Delayed ack and held output under stall.
        issue_one(4, 1'b0, 1'b0, 10'h0, 16'h0);
        fetch_one(3, 16'h1234);

        // Branch negative / positive from 0x0010.
        issue_one(0, 1'b1, 1'b0, 10'h008, 16'h0);
        chk("jump_to_10", imem_addr, 16'h0010);
        fetch_one(1, 16'h2000);
        issue_one(0, 1'b0, 1'b1, 10'h0, 16'hFFFC);
        chk("br_neg", imem_addr, 16'h000A);
        fetch_one(0, 16'h2001);
        issue_one(1, 1'b1, 1'b0, 10'h008, 16'h0);
        fetch_one(0, 16'h2002);
        issue_one(0, 1'b0, 1'b1, 10'h0, 16'h0003);
        chk("br_pos", imem_addr, 16'h0018);

        // Jump wins over branch.
        fetch_one(0, 16'h3000);
        issue_one(0, 1'b0, 1'b1, 10'h0, off_to(16'h8804));
        fetch_one(2, 16'h3001);
        chk("at_8804", pc, 16'h8804);
        issue_one(2, 1'b1, 1'b1, 10'h155, 16'h0040);
        chk("jump_prio", imem_addr, 16'h8AAA);

        // Sequential wrap at 0xFFFE.
        fetch_one(0, 16'h4000);
        issue_one(0, 1'b0, 1'b1, 10'h0, off_to(16'hFFFE));
        fetch_one(0, 16'h4001);
        issue_one(0, 1'b0, 1'b0, 10'h0, 16'h0);
        chk("wrap", imem_addr, 16'h0000);

        // Async reset in ISSUE, between edges.
        fetch_one(0, 16'h5000);
        #2 rst = 1'b1;
        #1;
        chk("arst_issue_valid", {15'd0, instr_valid}, 16'd0);
        chk("arst_issue_req", {15'd0, imem_req}, 16'd0);
        step();
        rst = 1'b0;
        step();
        exp_pc = 16'h0000;
        // Async reset in FETCH, between edges.
        #2 rst = 1'b1;
        #1;
        chk("arst_fetch_req", {15'd0, imem_req}, 16'd0);
        chk("arst_fetch_addr", imem_addr, 16'h0000);
        step();
        rst = 1'b0;
        step();

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] kind;
            fetch_one(int'($urandom_range(0, 4)), 16'($urandom));
            kind = 2'($urandom);
            issue_one(int'($urandom_range(0, 3)), kind[1], kind[0], 10'($urandom),
                      16'($urandom));
        end

        // Ack timeout, sticky error, late ack ignored.
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_req", {15'd0, imem_req}, 16'd1);
            chk("to_err", {15'd0, fetch_err}, 16'd0);
        end
        step();
        chk("halt_req", {15'd0, imem_req}, 16'd0);
        chk("halt_err", {15'd0, fetch_err}, 16'd1);
        imem_ack  = 1'b1;
        imem_data = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_ack_req", {15'd0, imem_req}, 16'd0);
            chk("late_ack_valid", {15'd0, instr_valid}, 16'd0);
            chk("late_ack_err", {15'd0, fetch_err}, 16'd1);
        end

        // Reset recovers; ack during reset and the reset-exit cycle is ignored.
        rst = 1'b1;
        step();
        chk("rec_err", {15'd0, fetch_err}, 16'd0);
        chk("rec_addr", imem_addr, 16'h0000);
        rst = 1'b0;
        step();
        imem_ack = 1'b0;
        chk("rec_valid", {15'd0, instr_valid}, 16'd0);
        exp_pc = 16'h0000;
        fetch_one(1, 16'h0401);
        chk("rec_err_after", {15'd0, fetch_err}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
